// File: rtl/toy_bpu_rob_ctrl.sv
// Front-end fetch ROB controller: in-order slot allocation, ID steering of
// icache acks and bp2 results, flush fan-out and in-order head drain.
module toy_bpu_rob_ctrl #(
  parameter int ROB_DEPTH        = 8,
  parameter int ID_W             = $clog2(ROB_DEPTH),
  parameter int FETCH_DATA_WIDTH = 32
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            alloc_req,
  output logic                            alloc_gnt,
  output logic [ID_W-1:0]                 alloc_id,
  input  logic                            icache_ack_vld,
  input  logic [ID_W-1:0]                 icache_ack_id,
  input  logic                            bp2_vld,
  input  logic                            bp2_flush,
  input  logic [ID_W-1:0]                 bp2_id,
  input  logic                            fe_ctrl_flush,
  output logic [ROB_DEPTH-1:0]            ent_prealloc,
  output logic [ROB_DEPTH-1:0]            ent_ack_vld,
  output logic [ROB_DEPTH-1:0]            ent_bp2_vld,
  output logic [ROB_DEPTH-1:0]            ent_bp2_flush,
  output logic                            ent_fe_flush,
  input  logic [ROB_DEPTH-1:0]            ent_wait_0,
  input  logic [ROB_DEPTH-1:0]            ent_valid,
  input  logic [ROB_DEPTH-1:0]            ent_invalid,
  input  logic [ROB_DEPTH*FETCH_DATA_WIDTH-1:0] ent_pld,
  output logic [ROB_DEPTH-1:0]            ent_rden,
  output logic [ROB_DEPTH-1:0]            ent_bypass,
  output logic                            out_vld,
  input  logic                            out_rdy,
  output logic [ID_W-1:0]                 out_id,
  output logic [FETCH_DATA_WIDTH-1:0]     out_pld
);

  localparam int PW = ID_W + 1;

  logic [PW-1:0]        r_head;
  logic [PW-1:0]        r_tail;
  logic [PW-1:0]        w_cnt;
  logic [ID_W-1:0]      w_hid;
  logic [ID_W-1:0]      w_tid;
  logic                 w_nempty;
  logic                 w_full;
  logic [ID_W-1:0]      w_ack_off;
  logic [ID_W-1:0]      w_bp2_off;
  logic                 w_ack_live;
  logic                 w_bp2_live;
  logic                 w_bp2_ok;
  logic [ROB_DEPTH-1:0] w_young;
  logic                 w_byp;
  logic                 w_rd_vld;
  logic                 w_rd;

  assign w_cnt    = r_tail - r_head;
  assign w_hid    = r_head[ID_W-1:0];
  assign w_tid    = r_tail[ID_W-1:0];
  assign w_nempty = (w_cnt != '0);
  assign w_full   = w_cnt[ID_W];

  // Liveness by distance from head: live iff offset < count.
  assign w_ack_off  = icache_ack_id - w_hid;
  assign w_bp2_off  = bp2_id - w_hid;
  assign w_ack_live = ({1'b0, w_ack_off} < w_cnt);
  assign w_bp2_live = ({1'b0, w_bp2_off} < w_cnt);

  always_comb begin
    w_young = '0;
    for (int i = 0; i < ROB_DEPTH; i++) begin
      logic [ID_W-1:0] v_off;
      v_off = ID_W'(i) - w_hid;
      w_young[i] = ({1'b0, v_off} < w_cnt) && (v_off > w_bp2_off);
    end
  end

  assign alloc_gnt    = alloc_req & ~w_full & ~fe_ctrl_flush;
  assign alloc_id     = w_tid;
  assign ent_prealloc = ROB_DEPTH'(alloc_gnt) << w_tid;
  assign ent_fe_flush = fe_ctrl_flush;

  assign ent_ack_vld =
    ROB_DEPTH'(icache_ack_vld & w_ack_live & ~fe_ctrl_flush)
    << icache_ack_id;

  assign w_bp2_ok      = bp2_vld & w_bp2_live & ~fe_ctrl_flush;
  assign ent_bp2_vld   = ROB_DEPTH'(w_bp2_ok) << bp2_id;
  assign ent_bp2_flush = (w_bp2_ok & bp2_flush) ? w_young : '0;

  // Killed slots win over valid, but must wait for their icache ack.
  assign w_byp = w_nempty & ~fe_ctrl_flush
               & ent_invalid[w_hid] & ~ent_wait_0[w_hid];
  assign w_rd_vld = w_nempty & ~fe_ctrl_flush
                  & ~ent_invalid[w_hid] & ent_valid[w_hid];
  assign w_rd = w_rd_vld & out_rdy;

  assign out_vld    = w_rd_vld;
  assign ent_rden   = ROB_DEPTH'(w_rd) << w_hid;
  assign ent_bypass = ROB_DEPTH'(w_byp) << w_hid;
  assign out_id     = w_nempty ? w_hid : '0;
  assign out_pld    = w_nempty
    ? ent_pld[int'(w_hid)*FETCH_DATA_WIDTH +: FETCH_DATA_WIDTH]
    : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head <= '0;
      r_tail <= '0;
    end else if (fe_ctrl_flush) begin
      r_head <= '0;
      r_tail <= '0;
    end else begin
      r_tail <= r_tail + PW'(alloc_gnt);
      r_head <= r_head + PW'(w_rd | w_byp);
    end
  end

  a_ack_in_window: assert property (
    @(posedge clk) disable iff (!rst_n)
    icache_ack_vld |-> w_ack_live
  ) else $warning("rob_ctrl: dropped out-of-window ack id %0d",
                  icache_ack_id);

  a_bp2_in_window: assert property (
    @(posedge clk) disable iff (!rst_n)
    bp2_vld |-> w_bp2_live
  ) else $warning("rob_ctrl: dropped out-of-window bp2 id %0d", bp2_id);

endmodule

// File: tb/tb_toy_bpu_rob_ctrl.sv
// Bench for toy_bpu_rob_ctrl: emulated ROB entries, a queue-based
// reference model checked every cycle, and directed scenarios.
module tb_toy_bpu_rob_ctrl;
  localparam int D  = 8;
  localparam int IW = 3;
  localparam int W  = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic alloc_req, alloc_gnt;
  logic [IW-1:0] alloc_id;
  logic icache_ack_vld;
  logic [IW-1:0] icache_ack_id;
  logic bp2_vld, bp2_flush;
  logic [IW-1:0] bp2_id;
  logic fe_ctrl_flush;
  logic [D-1:0] ent_prealloc, ent_ack_vld, ent_bp2_vld, ent_bp2_flush;
  logic ent_fe_flush;
  logic [D-1:0] ent_wait_0, ent_valid, ent_invalid;
  logic [D*W-1:0] ent_pld;
  logic [D-1:0] ent_rden, ent_bypass;
  logic out_vld, out_rdy;
  logic [IW-1:0] out_id;
  logic [W-1:0] out_pld;
  logic [W-1:0] ack_data;

  toy_bpu_rob_ctrl #(.ROB_DEPTH(D), .ID_W(IW), .FETCH_DATA_WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .alloc_req(alloc_req), .alloc_gnt(alloc_gnt), .alloc_id(alloc_id),
    .icache_ack_vld(icache_ack_vld), .icache_ack_id(icache_ack_id),
    .bp2_vld(bp2_vld), .bp2_flush(bp2_flush), .bp2_id(bp2_id),
    .fe_ctrl_flush(fe_ctrl_flush),
    .ent_prealloc(ent_prealloc), .ent_ack_vld(ent_ack_vld),
    .ent_bp2_vld(ent_bp2_vld), .ent_bp2_flush(ent_bp2_flush),
    .ent_fe_flush(ent_fe_flush),
    .ent_wait_0(ent_wait_0), .ent_valid(ent_valid),
    .ent_invalid(ent_invalid), .ent_pld(ent_pld),
    .ent_rden(ent_rden), .ent_bypass(ent_bypass),
    .out_vld(out_vld), .out_rdy(out_rdy),
    .out_id(out_id), .out_pld(out_pld)
  );

  // Emulated ROB entries reacting to the controller's strobes.
  logic [D-1:0] e_wait, e_ack, e_bp2, e_kill;
  logic [W-1:0] e_pld [D];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_wait <= '0; e_ack <= '0; e_bp2 <= '0; e_kill <= '0;
      for (int i = 0; i < D; i++) e_pld[i] <= '0;
    end else begin
      for (int i = 0; i < D; i++) begin
        if (ent_fe_flush || ent_rden[i] || ent_bypass[i]) begin
          e_wait[i] <= 1'b0; e_ack[i] <= 1'b0;
          e_bp2[i] <= 1'b0; e_kill[i] <= 1'b0;
        end else if (ent_prealloc[i]) begin
          e_wait[i] <= 1'b1; e_ack[i] <= 1'b0;
          e_bp2[i] <= 1'b0; e_kill[i] <= 1'b0;
        end else begin
          if (ent_ack_vld[i]) begin
            e_wait[i] <= 1'b0; e_ack[i] <= 1'b1; e_pld[i] <= ack_data;
          end
          if (ent_bp2_vld[i]) e_bp2[i] <= 1'b1;
          if (ent_bp2_flush[i]) e_kill[i] <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    ent_pld = '0;
    ent_wait_0 = e_wait;
    ent_valid = e_ack & e_bp2 & ~e_kill;
    ent_invalid = e_kill;
    for (int i = 0; i < D; i++) ent_pld[i*W +: W] = e_pld[i];
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp,
               $time);
    end
  endtask

  // Reference model: queue of live slot ids in age order, next tail id.
  int q[$];
  int nxt = 0;

  function automatic int qpos(int id);
    for (int k = 0; k < q.size(); k++) if (q[k] == id) return k;
    return -1;
  endfunction

  always @(negedge rst_n) begin
    q.delete();
    nxt = 0;
  end

  always @(negedge clk) begin : cmp
    logic e_gnt, e_ov;
    logic [D-1:0] e_pre, e_av, e_bv, e_bf, e_rd, e_by;
    logic [IW-1:0] e_oid;
    logic [W-1:0] e_opld;
    int ap, bp, h;
    if (rst_n) begin
      e_gnt = alloc_req && q.size() < D && !fe_ctrl_flush;
      e_pre = e_gnt ? (D'(1) << nxt) : '0;
      ap = qpos(int'(icache_ack_id));
      e_av = (icache_ack_vld && ap >= 0 && !fe_ctrl_flush)
           ? (D'(1) << icache_ack_id) : '0;
      bp = qpos(int'(bp2_id));
      e_bv = '0; e_bf = '0;
      if (bp2_vld && bp >= 0 && !fe_ctrl_flush) begin
        e_bv = D'(1) << bp2_id;
        if (bp2_flush)
          for (int k = bp + 1; k < q.size(); k++) e_bf[q[k]] = 1'b1;
      end
      e_ov = 1'b0; e_rd = '0; e_by = '0; e_oid = '0; e_opld = '0;
      if (q.size() > 0) begin
        h = q[0];
        e_oid = IW'(h);
        e_opld = ent_pld[h*W +: W];
        if (!fe_ctrl_flush) begin
          if (ent_invalid[h]) begin
            if (!ent_wait_0[h]) e_by[h] = 1'b1;
          end else if (ent_valid[h]) begin
            e_ov = 1'b1;
            if (out_rdy) e_rd[h] = 1'b1;
          end
        end
      end
      chk("alloc_gnt", alloc_gnt, e_gnt);
      chk("alloc_id", alloc_id, nxt);
      chk("ent_prealloc", ent_prealloc, e_pre);
      chk("ent_ack_vld", ent_ack_vld, e_av);
      chk("ent_bp2_vld", ent_bp2_vld, e_bv);
      chk("ent_bp2_flush", ent_bp2_flush, e_bf);
      chk("ent_fe_flush", ent_fe_flush, fe_ctrl_flush);
      chk("ent_rden", ent_rden, e_rd);
      chk("ent_bypass", ent_bypass, e_by);
      chk("out_vld", out_vld, e_ov);
      chk("out_id", out_id, e_oid);
      chk("out_pld", out_pld, e_opld);
      if (fe_ctrl_flush) begin
        q.delete();
        nxt = 0;
      end else begin
        if (e_rd != '0 || e_by != '0) void'(q.pop_front());
        if (e_gnt) begin
          q.push_back(nxt);
          nxt = (nxt + 1) % D;
        end
      end
    end
  end

  // Read/bypass log taken from the DUT, checked against literals.
  int log_id[$];
  logic [W-1:0] log_pld[$];
  int nbyp = 0;

  always @(negedge clk) begin
    if (rst_n && !fe_ctrl_flush) begin
      if (out_vld && out_rdy) begin
        log_id.push_back(int'(out_id));
        log_pld.push_back(out_pld);
      end
      if (ent_bypass != '0) nbyp++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alloc_req = 0; icache_ack_vld = 0; icache_ack_id = '0;
    bp2_vld = 0; bp2_flush = 0; bp2_id = '0;
    fe_ctrl_flush = 0; out_rdy = 0; ack_data = '0;
  endtask

  task automatic alloc_n(int n);
    alloc_req = 1;
    repeat (n) step();
    alloc_req = 0;
  endtask

  task automatic ack(int id);
    icache_ack_vld = 1;
    icache_ack_id = IW'(id);
    ack_data = 32'hC0DE_0000 + W'(id);
    step();
    icache_ack_vld = 0;
  endtask

  task automatic bp2(int id, logic fl);
    bp2_vld = 1; bp2_id = IW'(id); bp2_flush = fl;
    step();
    bp2_vld = 0; bp2_flush = 0;
  endtask

  task automatic flush();
    fe_ctrl_flush = 1;
    step();
    fe_ctrl_flush = 0;
  endtask

  task automatic wait_log(int n, int budget);
    int k = 0;
    while (log_id.size() < n && k < budget) begin
      step();
      k++;
    end
    chk("wait_log_size", log_id.size(), n);
  endtask

  initial begin
    idle();
    #12;
    chk("rst_gnt", alloc_gnt, 0);
    chk("rst_id", alloc_id, 0);
    chk("rst_out_vld", out_vld, 0);
    chk("rst_out_pld", out_pld, 0);
    chk("rst_bypass", ent_bypass, 0);
    rst_n = 1;
    step();

    // 1: fill to depth, ninth request refused
    alloc_req = 1;
    for (int i = 0; i < 9; i++) begin
      #1;
      chk("t1_gnt", alloc_gnt, (i < 8) ? 1 : 0);
      chk("t1_id", alloc_id, (i < 8) ? i : 0);
      step();
    end
    alloc_req = 0;
    chk("t1_count", q.size(), 8);
    flush();

    // 2: out-of-order acks, in-order reads
    log_id.delete(); log_pld.delete();
    alloc_n(4);
    ack(2); ack(0); ack(3); ack(1);
    out_rdy = 1;
    for (int i = 0; i < 4; i++) bp2(i, 1'b0);
    wait_log(4, 20);
    for (int k = 0; k < 4 && k < log_id.size(); k++) begin
      chk("t2_order", log_id[k], k);
      chk("t2_pld", log_pld[k], 32'hC0DE_0000 + k);
    end
    out_rdy = 0;
    flush();

    // 3: bp2 redirect on slot 1 kills 2..4
    log_id.delete(); log_pld.delete(); nbyp = 0;
    alloc_n(5);
    ack(0); ack(1); bp2(0, 1'b0);
    bp2_vld = 1; bp2_id = 3'd1; bp2_flush = 1;
    #1;
    chk("t3_mask", ent_bp2_flush, 8'b0001_1100);
    step();
    bp2_vld = 0; bp2_flush = 0;
    out_rdy = 1;
    repeat (6) step();
    chk("t3_reads", log_id.size(), 2);
    chk("t3_blocked_byp", nbyp, 0);
    chk("t3_blocked_vld", out_vld, 0);
    ack(2); ack(3); ack(4);
    repeat (4) step();
    chk("t3_byp", nbyp, 3);
    chk("t3_reads_after", log_id.size(), 2);
    chk("t3_empty", q.size(), 0);
    out_rdy = 0;
    flush();

    // 4: full, drain and grant do not overlap
    alloc_n(8);
    ack(0); bp2(0, 1'b0);
    alloc_req = 1; out_rdy = 1;
    #1;
    chk("t4_gnt_full", alloc_gnt, 0);
    chk("t4_rden", ent_rden, 8'b0000_0001);
    step();
    out_rdy = 0;
    #1;
    chk("t4_gnt_next", alloc_gnt, 1);
    chk("t4_id_wrap", alloc_id, 0);
    step();
    #1;
    chk("t4_full_again", alloc_gnt, 0);
    alloc_req = 0;
    chk("t4_count", q.size(), 8);
    flush();

    // 5: global flush suppresses everything
    alloc_n(6);
    fe_ctrl_flush = 1; alloc_req = 1;
    icache_ack_vld = 1; icache_ack_id = 3'd3;
    #1;
    chk("t5_gnt", alloc_gnt, 0);
    chk("t5_ack", ent_ack_vld, 0);
    chk("t5_fe_flush", ent_fe_flush, 1);
    step();
    idle();
    #1;
    chk("t5_id", alloc_id, 0);
    chk("t5_out_vld", out_vld, 0);
    chk("t5_count", q.size(), 0);

    // 6: out-of-window ack dropped
    alloc_n(3);
    icache_ack_vld = 1; icache_ack_id = 3'd6;
    #1;
    chk("t6_oow_ack", ent_ack_vld, 0);
    step();
    icache_ack_id = 3'd1;
    #1;
    chk("t6_in_ack", ent_ack_vld, 8'b0000_0010);
    step();
    icache_ack_vld = 0;

    // 7: async reset mid-operation
    alloc_req = 1;
    step();
    alloc_req = 0;
    #2;
    rst_n = 0;
    #1;
    chk("t7_id", alloc_id, 0);
    chk("t7_out_id", out_id, 0);
    chk("t7_bypass", ent_bypass, 0);
    #3;
    rst_n = 1;
    repeat (3) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
